isa_pnp_res_fetch: RTL and testbench
====================================

# isa_pnp_res_fetch

Sequencer between the ISA PnP register decoder and the PnP resource ROM. It fetches ROM bytes over a one-cycle registered read port and serves two host paths. The serial-isolation path shifts out the 72-bit serial identifier as 0x55/0xAA read pairs. The resource-data path serves auto-incrementing Resource Data reads with a Status-ready flag. Optionally it computes the LFSR identifier checksum in hardware and substitutes it for ROM byte 8.

## Interface
- ADDR_W, 8, ROM address width
- RES_START, 8'h09, pointer value loaded after a successful isolation
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rom_addr  out  ADDR_W  ROM address; data valid on rom_data the following cycle
- rom_data  in  8  ROM read data
- iso_start  in  1  pulse: Wake[CSN=0], enter isolation
- iso_rd  in  1  pulse: Serial Isolation register read
- iso_sense  in  1  another card drove 0x55/0xAA during this iso_rd
- iso_rdata  out  8  isolation read byte
- iso_drive  out  1  card drives SD bus for this read
- iso_done  out  1  one-cycle pulse: all 72 bits survived
- iso_lost  out  1  level: card lost isolation; cleared by iso_start
- res_reset  in  1  pulse: reset resource pointer to 0
- res_rd  in  1  pulse: Resource Data register read
- res_rdata  out  8  resource byte
- res_ready  out  1  Status register bit 0
- busy  out  1  checksum scan in progress
- cksum  out  8  computed checksum

## Operation
- States: SCAN, IDLE, ISO_FETCH, ISO_WAIT, ISO_BIT, RES_FETCH, RES_WAIT, RES_READY.
- Fetch: *_FETCH drives rom_addr=ptr. *_WAIT captures rom_data. Next cycle enters ISO_BIT or RES_READY. Byte address 8 is replaced by cksum when the checksum option is compiled in.
- SCAN: reads addresses 0..7 in order. For each byte, it applies 8 LFSR steps LSB first: c = {c[0]^c[1]^bit, c[7:1]}, starting from 8'h6A. When done, it drops busy and goes to IDLE.
- iso_start: ptr=0, bit counter=0, iso_lost=0, then ISO_FETCH. If iso_start arrives during SCAN it is latched and executed after SCAN.
- ISO_BIT handles bit b = shreg[0]:
  - First iso_rd of a pair returns 0x55 and iso_drive=1 if b=1. It returns 0x00 and iso_drive=0 if b=0.
  - The second read returns 0xAA or 0x00 on the same rule.
  - iso_sense is sticky across the pair.
  - After the second read, if b=0 and sense was seen: iso_lost=1, go to IDLE.
  - Otherwise shift, increment the counter, and after every 8th bit increment ptr and go to ISO_FETCH.
  - After bit 71: pulse iso_done, set ptr=RES_START, go to RES_FETCH.
- An iso_rd arriving in ISO_FETCH/ISO_WAIT is held one-deep and serviced on entering ISO_BIT.
- res_reset: ptr=0, then RES_FETCH. If res_reset and iso_start arrive together, iso_start wins (ptr=0 either way).
- RES_READY: res_ready=1. res_rd loads res_rdata, clears res_ready, increments ptr (wraps 2^ADDR_W-1 to 0), and goes to RES_FETCH.
- Ignored inputs:
  - res_rd outside RES_READY is ignored; res_rdata holds its value.
  - iso_rd outside isolation states is ignored.
  - res_rd during isolation is ignored.

## Timing
- Reset values: rom_addr=0, iso_rdata=0, iso_drive=0, iso_done=0, iso_lost=0, res_rdata=0, res_ready=0, cksum=8'h6A, busy=1 (option on) or 0 (off).
- Fetch latency: 3 cycles from entering *_FETCH to res_ready rising or ISO_BIT.
- iso_rdata and iso_drive update the cycle after iso_rd. res_rdata updates the cycle after res_rd.
- SCAN completes 17 cycles after rst_n deasserts (8 bytes × 2 cycles + 1).
- rst_n asserted mid-operation aborts everything: pending reads are dropped and SCAN restarts.

## Configuration
- PNP_HW_CKSUM_EN defined:
  - SCAN state exists.
  - Byte 8 is substituted with cksum on both paths.
  - busy=1 from reset until the scan completes.
- PNP_HW_CKSUM_EN undefined:
  - Reset goes directly to IDLE; busy is tied 0.
  - cksum stays 8'h6A.
  - ROM byte 8 is passed through unchanged.

## Test plan
- Macro on, ROM bytes 0-7 = 0x00, release reset -> busy falls at cycle 17, cksum=0xB5. A res_reset followed by 9 res_rd returns 00×8 then B5.
- Isolation with bytes 34 12 1F 0C 01 00 00 00 and iso_sense=0 -> 144 iso_rd yield 0x55/0xAA pairs only for 1 bits, LSB first. Byte 0x34 gives pairs for bits 2, 4, 5. iso_done pulses; the next res_rd returns the byte at address 9.
- During isolation, iso_sense=1 on a 0-bit pair (bit 0 of 0x34) -> iso_lost=1 after the second read. Further iso_rd return 0x00 with iso_drive=0.
- res_rd issued 1 cycle after a previous res_rd (res_ready=0) -> ignored, ptr unchanged, res_rdata held.
- iso_start and res_reset in the same cycle during SCAN -> isolation begins after busy falls, at ptr 0.
- Macro off, byte 8 = 0x5A -> 9th res_rd returns 0x5A, busy=0 from reset.

Source files
------------

// File: rtl/isa_pnp_res_fetch.sv
// isa_pnp_res_fetch
// Sequencer between the ISA PnP register decoder and the PnP resource ROM.
// It fetches ROM bytes through a one-cycle registered read port and serves two host paths:
//   - serial isolation: the 72-bit serial identifier is shifted out as 0x55/0xAA read pairs
//   - resource data: auto-incrementing reads, with a Status-ready flag
// Optional feature macro: PNP_HW_CKSUM_EN. When defined, the block scans ROM bytes 0..7
// after reset, computes the LFSR identifier checksum and substitutes it for ROM byte 8.
//
// state     | meaning
// SCAN      | checksum scan of ROM bytes 0..7 (only when the checksum option is built)
// IDLE      | no path active
// ISO_FETCH | rom_addr = ptr for the next identifier byte
// ISO_WAIT  | capture the identifier byte into the shift register
// ISO_BIT   | answer the iso_rd pair for the current identifier bit
// RES_FETCH | rom_addr = ptr for the next resource byte
// RES_WAIT  | capture the resource byte
// RES_READY | res_ready=1, waiting for res_rd
module isa_pnp_res_fetch #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] RES_START = ADDR_W'(9)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    input  logic              i_iso_start,
    input  logic              i_iso_rd,
    input  logic              i_iso_sense,
    output logic [7:0]        o_iso_rdata,
    output logic              o_iso_drive,
    output logic              o_iso_done,
    output logic              o_iso_lost,
    input  logic              i_res_reset,
    input  logic              i_res_rd,
    output logic [7:0]        o_res_rdata,
    output logic              o_res_ready,
    output logic              o_busy,
    output logic [7:0]        o_cksum
);

    typedef enum logic [2:0] {
        SCAN, IDLE, ISO_FETCH, ISO_WAIT, ISO_BIT, RES_FETCH, RES_WAIT, RES_READY
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_shreg;
    logic [6:0]        r_bitcnt;
    logic              r_half;
    logic              r_sense;
    logic              r_iso_pend;
    logic              r_pend_sense;
    logic [7:0]        r_iso_rdata;
    logic              r_iso_drive;
    logic              r_iso_done;
    logic              r_iso_lost;
    logic [7:0]        r_res_rdata;
    logic              r_res_ready;

    logic [7:0]        w_fetch_byte;
    logic              w_bit;
    logic              w_rd;
    logic              w_sense;
    logic              w_sense_pair;
    logic [7:0]        w_iso_byte;
    logic              w_start;
    logic              w_rreset;

`ifdef PNP_HW_CKSUM_EN
    logic              r_scan_ph;
    logic              r_start_pend;
    logic              r_rreset_pend;
    logic              r_busy;
    logic [7:0]        r_cksum;
    logic              w_scan_end;

    // Eight LFSR steps over one byte, least significant bit first.
    function automatic logic [7:0] lfsr_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = {r[0] ^ r[1] ^ d[i], r[7:1]};
        end
        return r;
    endfunction

    // Scan ends after byte 7 has been folded in (ptr has reached 8, address phase).
    assign w_scan_end = (r_state == SCAN) && !r_scan_ph && (r_ptr == ADDR_W'(8));
    // Commands seen during SCAN are deferred to the cycle the scan ends.
    assign w_start    = (r_state == SCAN) ? (w_scan_end && (r_start_pend || i_iso_start))
                                          : i_iso_start;
    assign w_rreset   = (r_state == SCAN) ? (w_scan_end && (r_rreset_pend || i_res_reset))
                                          : i_res_reset;
    assign o_busy     = r_busy;
    assign o_cksum    = r_cksum;

    // Checksum scan bookkeeping: address/data phase, checksum, deferred commands, busy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scan_ph     <= 1'b0;
            r_start_pend  <= 1'b0;
            r_rreset_pend <= 1'b0;
            r_busy        <= 1'b1;
            r_cksum       <= 8'h6A;
        end else if (r_state == SCAN) begin
            r_scan_ph <= !r_scan_ph;
            if (r_scan_ph) begin
                r_cksum <= lfsr_byte(r_cksum, i_rom_data);
            end
            if (i_iso_start) begin
                r_start_pend <= 1'b1;
            end
            if (i_res_reset) begin
                r_rreset_pend <= 1'b1;
            end
            if (w_scan_end) begin
                r_busy <= 1'b0;
            end
        end
    end
`else
    assign w_start  = i_iso_start;
    assign w_rreset = i_res_reset;
    assign o_busy   = 1'b0;
    assign o_cksum  = 8'h6A;
`endif

    // Byte 8 of the ROM is replaced by the computed checksum when the option is built.
    always_comb begin
        w_fetch_byte = i_rom_data;
`ifdef PNP_HW_CKSUM_EN
        if (r_ptr == ADDR_W'(8)) begin
            w_fetch_byte = r_cksum;
        end
`endif
    end

    // A held iso_rd is serviced ahead of a new one and carries its own sense sample.
    assign w_bit        = r_shreg[0];
    assign w_rd         = i_iso_rd | r_iso_pend;
    assign w_sense      = r_iso_pend ? r_pend_sense : i_iso_sense;
    assign w_sense_pair = r_sense | w_sense;
    assign w_iso_byte   = w_bit ? (r_half ? 8'hAA : 8'h55) : 8'h00;

    // Main sequencer: iso_start beats res_reset, both beat the current state's work.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
`ifdef PNP_HW_CKSUM_EN
            r_state <= SCAN;
`else
            r_state <= IDLE;
`endif
            r_ptr        <= '0;
            r_shreg      <= 8'h00;
            r_bitcnt     <= 7'd0;
            r_half       <= 1'b0;
            r_sense      <= 1'b0;
            r_iso_pend   <= 1'b0;
            r_pend_sense <= 1'b0;
            r_iso_rdata  <= 8'h00;
            r_iso_drive  <= 1'b0;
            r_iso_done   <= 1'b0;
            r_iso_lost   <= 1'b0;
            r_res_rdata  <= 8'h00;
            r_res_ready  <= 1'b0;
        end else begin
            r_iso_done <= 1'b0;
            if (w_start) begin
                r_ptr       <= '0;
                r_bitcnt    <= 7'd0;
                r_half      <= 1'b0;
                r_sense     <= 1'b0;
                r_iso_pend  <= 1'b0;
                r_iso_lost  <= 1'b0;
                r_res_ready <= 1'b0;
                r_state     <= ISO_FETCH;
            end else if (w_rreset) begin
                r_ptr       <= '0;
                r_iso_pend  <= 1'b0;
                r_res_ready <= 1'b0;
                r_state     <= RES_FETCH;
            end else begin
                case (r_state)
`ifdef PNP_HW_CKSUM_EN
                    SCAN: begin
                        if (w_scan_end) begin
                            r_ptr   <= '0;
                            r_state <= IDLE;
                        end else if (r_scan_ph) begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end
`endif
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    ISO_FETCH, ISO_WAIT: begin
                        if (i_iso_rd) begin
                            r_iso_pend   <= 1'b1;
                            r_pend_sense <= i_iso_sense;
                        end
                        if (r_state == ISO_WAIT) begin
                            r_shreg <= w_fetch_byte;
                            r_state <= ISO_BIT;
                        end else begin
                            r_state <= ISO_WAIT;
                        end
                    end
                    ISO_BIT: begin
                        r_iso_pend <= r_iso_pend & i_iso_rd;
                        if (r_iso_pend && i_iso_rd) begin
                            r_pend_sense <= i_iso_sense;
                        end
                        if (w_rd) begin
                            r_iso_rdata <= w_iso_byte;
                            r_iso_drive <= w_bit;
                            if (!r_half) begin
                                r_half  <= 1'b1;
                                r_sense <= w_sense;
                            end else begin
                                r_half  <= 1'b0;
                                r_sense <= 1'b0;
                                if (!w_bit && w_sense_pair) begin
                                    r_iso_lost <= 1'b1;
                                    r_iso_pend <= 1'b0;
                                    r_state    <= IDLE;
                                end else begin
                                    r_shreg  <= {1'b0, r_shreg[7:1]};
                                    r_bitcnt <= r_bitcnt + 7'd1;
                                    if (r_bitcnt == 7'd71) begin
                                        r_iso_done <= 1'b1;
                                        r_iso_pend <= 1'b0;
                                        r_bitcnt   <= 7'd0;
                                        r_ptr      <= RES_START;
                                        r_state    <= RES_FETCH;
                                    end else if (r_bitcnt[2:0] == 3'd7) begin
                                        r_ptr   <= r_ptr + ADDR_W'(1);
                                        r_state <= ISO_FETCH;
                                    end
                                end
                            end
                        end
                    end
                    RES_FETCH: begin
                        r_state <= RES_WAIT;
                    end
                    RES_WAIT: begin
                        r_shreg     <= w_fetch_byte;
                        r_res_ready <= 1'b1;
                        r_state     <= RES_READY;
                    end
                    RES_READY: begin
                        if (i_res_rd) begin
                            r_res_rdata <= r_shreg;
                            r_res_ready <= 1'b0;
                            r_ptr       <= r_ptr + ADDR_W'(1);
                            r_state     <= RES_FETCH;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // The pointer register is the ROM address; it is settled during every *_FETCH cycle.
    assign o_rom_addr  = r_ptr;
    assign o_iso_rdata = r_iso_rdata;
    assign o_iso_drive = r_iso_drive;
    assign o_iso_done  = r_iso_done;
    assign o_iso_lost  = r_iso_lost;
    assign o_res_rdata = r_res_rdata;
    assign o_res_ready = r_res_ready;

endmodule

// File: tb/tb_isa_pnp_res_fetch.sv
// Directed bench for isa_pnp_res_fetch with a registered-read ROM model.
// Works in both builds; checksum-only steps sit under PNP_HW_CKSUM_EN.
module tb_isa_pnp_res_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic       iso_start, iso_rd, iso_sense;
    logic [7:0] iso_rdata;
    logic       iso_drive, iso_done, iso_lost;
    logic       res_reset, res_rd;
    logic [7:0] res_rdata;
    logic       res_ready, busy;
    logic [7:0] cksum;

    logic [7:0] mem [256];
    logic [7:0] id  [9];
    logic [7:0] exp8;
    int         total = 0;
    int         bad = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    // ROM model: one-cycle registered read
    always @(posedge clk) rom_data <= mem[rom_addr];

    // iso_done pulse counter
    always @(negedge clk) if (iso_done === 1'b1) done_cnt++;

    isa_pnp_res_fetch dut (
        .i_clk(clk), .i_rst_n(rst_n), .o_rom_addr(rom_addr), .i_rom_data(rom_data),
        .i_iso_start(iso_start), .i_iso_rd(iso_rd), .i_iso_sense(iso_sense),
        .o_iso_rdata(iso_rdata), .o_iso_drive(iso_drive), .o_iso_done(iso_done),
        .o_iso_lost(iso_lost), .i_res_reset(res_reset), .i_res_rd(res_rd),
        .o_res_rdata(res_rdata), .o_res_ready(res_ready), .o_busy(busy), .o_cksum(cksum)
    );

`ifdef PNP_HW_CKSUM_EN
    function automatic logic [7:0] model_cksum();
        logic [7:0] c;
        c = 8'h6A;
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 8; i++)
                c = {c[0] ^ c[1] ^ mem[k][i], c[7:1]};
        return c;
    endfunction
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (res_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, {31'd0, res_ready}, 32'd1);
    endtask

    task automatic res_read(input logic [7:0] expv, input string tag);
        wait_ready(tag);
        res_rd = 1'b1;
        @(negedge clk);
        res_rd = 1'b0;
        chk(tag, {24'd0, res_rdata}, {24'd0, expv});
        chk({tag, "_clr"}, {31'd0, res_ready}, 32'd0);
    endtask

    task automatic iso_read(input logic s, input logic [7:0] expd, input logic expdr,
                            input int lat, input string tag);
        iso_rd    = 1'b1;
        iso_sense = s;
        @(negedge clk);
        iso_rd    = 1'b0;
        iso_sense = 1'b0;
        repeat (lat - 1) @(negedge clk);
        chk({tag, "_d"}, {24'd0, iso_rdata}, {24'd0, expd});
        chk({tag, "_drv"}, {31'd0, iso_drive}, {31'd0, expdr});
        repeat (4 - lat) @(negedge clk);
    endtask

    initial begin
        logic       bb;
        logic [7:0] ea;
        logic [7:0] a;
        int         d0;

        rst_n = 1'b0; iso_start = 1'b0; iso_rd = 1'b0; iso_sense = 1'b0;
        res_reset = 1'b0; res_rd = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h1F; mem[3] = 8'h0C;
        mem[4] = 8'h01; mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00;
        mem[8] = 8'h5A; mem[9] = 8'hC3;
`ifdef PNP_HW_CKSUM_EN
        exp8 = model_cksum();
`else
        exp8 = mem[8];
`endif
        for (int k = 0; k < 8; k++) id[k] = mem[k];
        id[8] = exp8;

        repeat (3) @(negedge clk);
        chk("rst_addr", {24'd0, rom_addr}, 32'd0);
        chk("rst_irdata", {24'd0, iso_rdata}, 32'd0);
        chk("rst_drive", {31'd0, iso_drive}, 32'd0);
        chk("rst_done", {31'd0, iso_done}, 32'd0);
        chk("rst_lost", {31'd0, iso_lost}, 32'd0);
        chk("rst_rrdata", {24'd0, res_rdata}, 32'd0);
        chk("rst_ready", {31'd0, res_ready}, 32'd0);
        chk("rst_cksum", {24'd0, cksum}, 32'h6A);
`ifdef PNP_HW_CKSUM_EN
        chk("rst_busy", {31'd0, busy}, 32'd1);
`else
        chk("rst_busy", {31'd0, busy}, 32'd0);
`endif
        rst_n = 1'b1;

`ifdef PNP_HW_CKSUM_EN
        // iso_start + res_reset together during SCAN; isolation must follow at ptr 0
        repeat (4) @(negedge clk);
        iso_start = 1'b1; res_reset = 1'b1;
        @(negedge clk);
        iso_start = 1'b0; res_reset = 1'b0;
        repeat (11) @(negedge clk);
        chk("busy_c16", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("busy_c17", {31'd0, busy}, 32'd0);
        chk("cksum", {24'd0, cksum}, {24'd0, exp8});
        iso_read(1'b0, 8'h00, 1'b0, 3, "scan_iso0");
        iso_read(1'b0, 8'h00, 1'b0, 1, "scan_iso1");
        iso_read(1'b0, 8'h00, 1'b0, 1, "scan_iso2");
        iso_read(1'b0, 8'h00, 1'b0, 1, "scan_iso3");
        iso_read(1'b0, 8'h55, 1'b1, 1, "scan_iso4");
        iso_read(1'b0, 8'hAA, 1'b1, 1, "scan_iso5");
`else
        @(negedge clk);
        chk("busy_off", {31'd0, busy}, 32'd0);
`endif

        // res_reset latency and the first nine resource bytes
        res_reset = 1'b1;
        @(negedge clk);
        res_reset = 1'b0;
        chk("lat_c1", {31'd0, res_ready}, 32'd0);
        @(negedge clk);
        chk("lat_c2", {31'd0, res_ready}, 32'd0);
        @(negedge clk);
        chk("lat_c3", {31'd0, res_ready}, 32'd1);
        for (int k = 0; k < 9; k++) begin
            res_read((k == 8) ? exp8 : mem[k], "res9");
            if (k == 3) begin
                res_rd = 1'b1;
                @(negedge clk);
                res_rd = 1'b0;
                chk("res_rd_ign", {24'd0, res_rdata}, {24'd0, mem[3]});
            end
        end

        // full isolation, no contention
        d0 = done_cnt;
        iso_start = 1'b1;
        @(negedge clk);
        iso_start = 1'b0;
        for (int i = 0; i < 72; i++) begin
            bb = id[i / 8][i % 8];
            if (i == 20) begin
                res_rd = 1'b1;
                @(negedge clk);
                res_rd = 1'b0;
                chk("res_rd_iso", {24'd0, res_rdata}, {24'd0, exp8});
            end
            iso_read(1'b0, bb ? 8'h55 : 8'h00, bb, (i == 0) ? 3 : 1, "iso_a");
            iso_read(1'b0, bb ? 8'hAA : 8'h00, bb, 1, "iso_b");
        end
        chk("iso_done_cnt", done_cnt - d0, 32'd1);
        chk("iso_nolost", {31'd0, iso_lost}, 32'd0);
        res_read(mem[9], "res_after_iso");

        // contention on a 0 bit: sense on the first read only, sticky across the pair
        iso_start = 1'b1;
        @(negedge clk);
        iso_start = 1'b0;
        iso_read(1'b1, 8'h00, 1'b0, 3, "lost1");
        chk("lost_after1", {31'd0, iso_lost}, 32'd0);
        iso_read(1'b0, 8'h00, 1'b0, 1, "lost2");
        chk("lost_after2", {31'd0, iso_lost}, 32'd1);
        iso_read(1'b0, 8'h00, 1'b0, 1, "lost3");
        chk("lost_after3", {31'd0, iso_lost}, 32'd1);
        iso_start = 1'b1;
        @(negedge clk);
        iso_start = 1'b0;
        chk("lost_clr", {31'd0, iso_lost}, 32'd0);

        // pointer wrap 255 -> 0
        res_reset = 1'b1;
        @(negedge clk);
        res_reset = 1'b0;
        for (int k = 0; k < 257; k++) begin
            a  = 8'(k);
            ea = (a == 8'd8) ? exp8 : mem[a];
            res_read(ea, "wrap");
        end

        // asynchronous reset mid-operation
        wait_ready("pre_rst");
        chk("pre_rst_addr", {24'd0, rom_addr}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", {24'd0, rom_addr}, 32'd0);
        chk("mid_rst_ready", {31'd0, res_ready}, 32'd0);
        chk("mid_rst_rdata", {24'd0, res_rdata}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        res_rd = 1'b1;
        @(negedge clk);
        res_rd = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, res_ready}, 32'd0);
        chk("post_rst_rdata", {24'd0, res_rdata}, 32'd0);
`ifdef PNP_HW_CKSUM_EN
        chk("post_rst_busy", {31'd0, busy}, 32'd1);
`else
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
